// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: glyph patterns and scan FSM states.
// Glyphs are active-low and ordered {g,f,e,d,c,b,a}.
// No ports; imported by seg7_decoder and seven_seg_scanner.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic {
    ST_ON  = 1'b0,
    ST_GAP = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-7-segment decoder (active-low segments, {g,f,e,d,c,b,a}).
// Ports: value [WIDTH-1:0] in -> seg_n [6:0] out. Values 0..15 show hex; anything larger shows a dash.
// Zero latency, no state.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  output logic [6:0]       seg_n
);

  // Widen to at least a nibble so narrow digit buses still index the hex table.
  localparam int EW = (WIDTH > 4) ? WIDTH : 4;

  logic [EW-1:0] v_ext;

  always_comb begin
    v_ext = EW'(value);
    seg_n = SEG_DASH;
    if ((v_ext >> 4) == '0) begin
      case (v_ext[3:0])
        4'h0: seg_n = SEG_0;
        4'h1: seg_n = SEG_1;
        4'h2: seg_n = SEG_2;
        4'h3: seg_n = SEG_3;
        4'h4: seg_n = SEG_4;
        4'h5: seg_n = SEG_5;
        4'h6: seg_n = SEG_6;
        4'h7: seg_n = SEG_7;
        4'h8: seg_n = SEG_8;
        4'h9: seg_n = SEG_9;
        4'hA: seg_n = SEG_A;
        4'hB: seg_n = SEG_B;
        4'hC: seg_n = SEG_C;
        4'hD: seg_n = SEG_D;
        4'hE: seg_n = SEG_E;
        default: seg_n = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment driver: one digit lit at a time, optional dead gap
// between digits, leading-zero blanking and whole-display blink.
// Ports: clk, reset (sync, active-high), digits/enable/blank_leading/blink/dp_mask in;
// an_n, seg_n, dp_n out (all active low, registered, 1-cycle latency from state and inputs).
module seven_seg_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int WIDTH       = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int GAP_CYCLES  = 2,
  parameter int BLINK_DIV   = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH*NUM_DIGITS-1:0] digits,
  input  logic                        enable,
  input  logic                        blank_leading,
  input  logic                        blink,
  input  logic [NUM_DIGITS-1:0]       dp_mask,
  output logic [NUM_DIGITS-1:0]       an_n,
  output logic [6:0]                  seg_n,
  output logic                        dp_n
);

  localparam int PRESC_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int PW = $clog2(PRESC_MAX + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] REF_LAST   = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? PW'(GAP_CYCLES - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] BLINK_LAST = SW'(BLINK_DIV - 1);

  state_t          state, state_nx;
  logic [PW-1:0]   presc, presc_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [SW-1:0]   scan_cnt, scan_cnt_nx;
  logic            blink_ph, blink_ph_nx;
  logic            advance;

  logic [NUM_DIGITS-1:0] blanked;
  logic                  all_zero;
  logic [WIDTH-1:0]      cur_digit;
  logic                  cur_blank;
  logic                  cur_dp;
  logic [6:0]            glyph;
  logic                  dark;
  logic [NUM_DIGITS-1:0] an_nx;
  logic [6:0]            seg_nx;
  logic                  dp_nx;

  // Scan FSM, prescaler, digit index and blink counters.
  always_comb begin
    state_nx    = state;
    presc_nx    = presc;
    idx_nx      = idx;
    scan_cnt_nx = scan_cnt;
    blink_ph_nx = blink_ph;
    advance     = 1'b0;

    case (state)
      ST_ON: begin
        if (presc == REF_LAST) begin
          presc_nx = '0;
          if (GAP_CYCLES == 0) advance  = 1'b1;
          else                 state_nx = ST_GAP;
        end else begin
          presc_nx = presc + PW'(1);
        end
      end
      ST_GAP: begin
        if (presc == GAP_LAST) begin
          presc_nx = '0;
          advance  = 1'b1;
          state_nx = ST_ON;
        end else begin
          presc_nx = presc + PW'(1);
        end
      end
      default: begin
        state_nx = ST_ON;
        presc_nx = '0;
      end
    endcase

    if (advance) begin
      if (idx == IDX_LAST) begin
        // Wrapping past the last digit completes one scan; this paces the blink.
        idx_nx = '0;
        if (scan_cnt == BLINK_LAST) begin
          scan_cnt_nx = '0;
          blink_ph_nx = ~blink_ph;
        end else begin
          scan_cnt_nx = scan_cnt + SW'(1);
        end
      end else begin
        idx_nx = idx + IW'(1);
      end
    end
  end

  // Leading-zero blanking: walk from the most significant digit down while everything seen is zero.
  always_comb begin
    blanked  = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero && (digits[WIDTH*i +: WIDTH] == '0);
      blanked[i] = blank_leading && all_zero && (i != 0);
    end
  end

  // Select the digit, blank flag and decimal point of the slot currently being scanned.
  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_digit = digits[WIDTH*i +: WIDTH];
        cur_blank = blanked[i];
        cur_dp    = dp_mask[i];
      end
    end
  end

  seg7_decoder #(.WIDTH(WIDTH)) u_decoder (
    .value (cur_digit),
    .seg_n (glyph)
  );

  always_comb begin
    dark   = (state == ST_GAP) || !enable || (blink && blink_ph) || cur_blank;
    an_nx  = '1;
    seg_nx = SEG_BLANK;
    dp_nx  = 1'b1;
    if (!dark) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IW'(i)) an_nx[i] = 1'b0;
      end
      seg_nx = glyph;
      dp_nx  = ~cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_ON;
      presc    <= '0;
      idx      <= '0;
      scan_cnt <= '0;
      blink_ph <= 1'b0;
      an_n     <= '1;
      seg_n    <= SEG_BLANK;
      dp_n     <= 1'b1;
    end else begin
      state    <= state_nx;
      presc    <= presc_nx;
      idx      <= idx_nx;
      scan_cnt <= scan_cnt_nx;
      blink_ph <= blink_ph_nx;
      an_n     <= an_nx;
      seg_n    <= seg_nx;
      dp_n     <= dp_nx;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: one instance with a 1-cycle gap, one without.
// Expected frames are queued as stimulus is applied and compared cycle by cycle afterwards.
// Ends with a one-line error/check summary.
module tb_seven_seg_scanner;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } frame_t;

  logic        clk;
  logic        reset;
  logic [15:0] digits;
  logic        enable;
  logic        blank_leading;
  logic        blink;
  logic [3:0]  dp_mask;

  logic [3:0]  an_n,  an_n_ng;
  logic [6:0]  seg_n, seg_n_ng;
  logic        dp_n,  dp_n_ng;

  int checks = 0;
  int errors = 0;

  frame_t sb[$];

  seven_seg_scanner #(
    .NUM_DIGITS(4), .WIDTH(4), .REFRESH_DIV(4), .GAP_CYCLES(1), .BLINK_DIV(2)
  ) dut (
    .clk(clk), .reset(reset), .digits(digits), .enable(enable),
    .blank_leading(blank_leading), .blink(blink), .dp_mask(dp_mask),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
  );

  seven_seg_scanner #(
    .NUM_DIGITS(4), .WIDTH(4), .REFRESH_DIV(4), .GAP_CYCLES(0), .BLINK_DIV(2)
  ) dut_nogap (
    .clk(clk), .reset(reset), .digits(digits), .enable(enable),
    .blank_leading(blank_leading), .blink(blink), .dp_mask(dp_mask),
    .an_n(an_n_ng), .seg_n(seg_n_ng), .dp_n(dp_n_ng)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int n);
    frame_t f;
    f.an  = an;
    f.seg = seg;
    f.dp  = dp;
    for (int k = 0; k < n; k++) sb.push_back(f);
  endtask

  task automatic push_dark(input int n);
    push(4'b1111, 7'h7F, 1'b1, n);
  endtask

  // One lit slot of the gapped instance: four lit cycles then one dark gap cycle.
  task automatic push_slot(input logic [3:0] an, input logic [6:0] seg);
    push(an, seg, 1'b1, 4);
    push_dark(1);
  endtask

  task automatic push_scan_1234();
    push_slot(4'b1110, 7'b0011001);
    push_slot(4'b1101, 7'b0110000);
    push_slot(4'b1011, 7'b0100100);
    push_slot(4'b0111, 7'b1111001);
  endtask

  // Advance one clock per queued frame and compare the selected instance's outputs.
  task automatic drain(input bit nogap, input string tag);
    frame_t exp_f;
    frame_t obs_f;
    while (sb.size() > 0) begin
      exp_f = sb.pop_front();
      @(posedge clk);
      #1;
      obs_f = nogap ? {an_n_ng, seg_n_ng, dp_n_ng} : {an_n, seg_n, dp_n};
      checks++;
      assert (obs_f === exp_f) else begin
        errors++;
        $error("FAIL %s #%0d: observed an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               tag, checks, obs_f.an, obs_f.seg, obs_f.dp, exp_f.an, exp_f.seg, exp_f.dp);
      end
    end
  endtask

  initial begin
    // Reset held three cycles: display dark throughout.
    reset         = 1'b1;
    digits        = 16'h1234;
    enable        = 1'b1;
    blank_leading = 1'b0;
    blink         = 1'b0;
    dp_mask       = 4'b0000;
    push_dark(3);
    drain(1'b0, "reset");

    // Release: digit 0 lit on the very next cycle, 20-cycle scan with gaps.
    reset = 1'b0;
    push_scan_1234();
    push_scan_1234();
    drain(1'b0, "scan_1234");

    // Leading-zero blanking on 0050: digits 3 and 2 dark, digit 0 still shows 0.
    digits        = 16'h0050;
    blank_leading = 1'b1;
    push_slot(4'b1110, 7'b1000000);
    push_slot(4'b1101, 7'b0010010);
    push_dark(10);
    drain(1'b0, "blank_0050");

    // All zero: only digit 0 lit.
    digits = 16'h0000;
    push_slot(4'b1110, 7'b1000000);
    push_dark(15);
    drain(1'b0, "blank_0000");

    // Blink from reset: two scans normal, then dark.
    reset         = 1'b1;
    digits        = 16'h1234;
    blank_leading = 1'b0;
    blink         = 1'b1;
    push_dark(1);
    drain(1'b0, "reset_blink");
    reset = 1'b0;
    push_scan_1234();
    push_scan_1234();
    push_dark(8);
    drain(1'b0, "blink");

    // Drop blink while dark (mid digit-1 slot): lit again on the next cycle.
    blink = 1'b0;
    push(4'b1101, 7'b0110000, 1'b1, 1);
    push_dark(1);
    push_slot(4'b1011, 7'b0100100);
    push_slot(4'b0111, 7'b1111001);
    drain(1'b0, "blink_drop");

    // Disable two cycles into the digit-2 slot.
    push_slot(4'b1110, 7'b0011001);
    push_slot(4'b1101, 7'b0110000);
    push(4'b1011, 7'b0100100, 1'b1, 2);
    drain(1'b0, "pre_disable");
    enable = 1'b0;
    push_dark(7);
    drain(1'b0, "disable");

    // Re-enable: scan kept running, so the gap shows dark and digit 0 follows.
    enable = 1'b1;
    push_dark(1);
    push_slot(4'b1110, 7'b0011001);
    push(4'b1101, 7'b0110000, 1'b1, 2);
    drain(1'b0, "reenable");

    // Reset mid-slot: aborts the digit-1 slot, digit 0 lit one cycle after release.
    reset = 1'b1;
    push_dark(1);
    drain(1'b0, "reset_mid");
    reset = 1'b0;
    push_slot(4'b1110, 7'b0011001);
    drain(1'b0, "after_reset");

    // No-gap instance: FA0C with a decimal point on digit 2 only.
    reset   = 1'b1;
    digits  = 16'hFA0C;
    dp_mask = 4'b0100;
    push_dark(1);
    drain(1'b1, "nogap_reset");
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      push(4'b1110, 7'b1000110, 1'b1, 4);
      push(4'b1101, 7'b1000000, 1'b1, 4);
      push(4'b1011, 7'b0001000, 1'b0, 4);
      push(4'b0111, 7'b0001110, 1'b1, 4);
    end
    drain(1'b1, "nogap_fa0c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
